// File: rtl/max_serial_if.sv
// ============================================================================
//  Module   : max_serial_if
//  Purpose  : Sample stream and result bus for max_serial. The producer side
//             drives in_valid/data_in and observes results (master); the
//             max_serial core consumes samples and drives results (slave).
//             index_out exists only when MAX_SERIAL_ARGMAX_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface max_serial_if #(
  parameter int WIDTH = 16,
  parameter int LEN   = 8
);
  localparam int IW = ($clog2(LEN) > 1) ? $clog2(LEN) : 1;

  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic             busy;
`ifdef MAX_SERIAL_ARGMAX_EN
  logic [IW-1:0]    index_out;
`endif

  // Sample producer / result consumer.
  modport master (
    output in_valid,
    output data_in,
    input  out_valid,
    input  data_out,
`ifdef MAX_SERIAL_ARGMAX_EN
    input  index_out,
`endif
    input  busy
  );

  // max_serial core.
  modport slave (
    input  in_valid,
    input  data_in,
    output out_valid,
    output data_out,
`ifdef MAX_SERIAL_ARGMAX_EN
    output index_out,
`endif
    output busy
  );

endinterface : max_serial_if

`default_nettype wire

// File: rtl/max_serial.sv
// ============================================================================
//  Module   : max_serial
//  Purpose  : Frame-wise running maximum over a serial sample stream. Every
//             LEN accepted samples form a frame; one clock after the last
//             sample the frame maximum appears on data_out with a one-cycle
//             out_valid pulse. clr aborts the partial frame.
//  Options  : MAX_SERIAL_ARGMAX_EN - also track the position of the maximum
//             (earliest index on ties) and drive index_out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_serial #(
  parameter int WIDTH = 16,
  parameter int LEN   = 8
) (
  input  wire        clk,
  input  wire        resetn,
  input  wire        clr,
  max_serial_if.slave bus
);

  localparam int            c_IW   = ($clog2(LEN) > 1) ? $clog2(LEN) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(LEN - 1);
  localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);

  localparam logic [0:0] c_ST_FIRST = 1'b0;
  localparam logic [0:0] c_ST_ACC   = 1'b1;

  logic [0:0]       r_state;
  logic [c_IW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_run_max;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_data_out;

  logic [0:0]       w_state_nxt;
  logic [c_IW-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0] w_max_nxt;
  logic             w_first;
  logic             w_frame_done;

`ifdef MAX_SERIAL_ARGMAX_EN
  logic [c_IW-1:0]  r_run_idx;
  logic [c_IW-1:0]  r_index_out;
  logic [c_IW-1:0]  w_idx_nxt;
`endif

  // State register plus datapath registers; results only move on frame completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_ST_FIRST;
      r_cnt       <= '0;
      r_run_max   <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
`ifdef MAX_SERIAL_ARGMAX_EN
      r_run_idx   <= '0;
      r_index_out <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_run_max   <= w_max_nxt;
      r_out_valid <= w_frame_done;
`ifdef MAX_SERIAL_ARGMAX_EN
      r_run_idx   <= w_idx_nxt;
`endif
      if (w_frame_done) begin
        r_data_out  <= w_max_nxt;
`ifdef MAX_SERIAL_ARGMAX_EN
        r_index_out <= w_idx_nxt;
`endif
      end
    end
  end

  // Next-state and datapath update; clr makes this cycle behave as FIRST so a
  // coincident sample opens the new frame and a coincident last sample never completes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_max_nxt    = r_run_max;
    w_frame_done = 1'b0;
`ifdef MAX_SERIAL_ARGMAX_EN
    w_idx_nxt    = r_run_idx;
`endif
    w_first      = clr || (r_state == c_ST_FIRST);

    if (clr) begin
      w_state_nxt = c_ST_FIRST;
      w_cnt_nxt   = '0;
    end

    if (bus.in_valid) begin
      if (w_first) begin
        w_max_nxt   = bus.data_in;
`ifdef MAX_SERIAL_ARGMAX_EN
        w_idx_nxt   = '0;
`endif
        w_cnt_nxt   = c_ONE;
        w_state_nxt = c_ST_ACC;
      end else begin
        // Strict compare keeps the earliest position on ties.
        if (bus.data_in > r_run_max) begin
          w_max_nxt = bus.data_in;
`ifdef MAX_SERIAL_ARGMAX_EN
          w_idx_nxt = r_cnt;
`endif
        end
        if (r_cnt == c_LAST) begin
          w_frame_done = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = c_ST_FIRST;
        end else begin
          w_cnt_nxt    = r_cnt + c_ONE;
        end
      end
    end
  end

  // Outputs: registered results and busy decoded from the state.
  always_comb begin
    bus.out_valid = r_out_valid;
    bus.data_out  = r_data_out;
    bus.busy      = (r_state == c_ST_ACC);
`ifdef MAX_SERIAL_ARGMAX_EN
    bus.index_out = r_index_out;
`endif
  end

endmodule : max_serial

`default_nettype wire

// File: tb/tb_max_serial.sv
// ============================================================================
//  Module   : tb_max_serial
//  Purpose  : Self-checking bench for max_serial (WIDTH=8, LEN=4). A queue
//             based frame model predicts every cycle's outputs; directed
//             scenarios are followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_serial;

  localparam int WIDTH = 8;
  localparam int LEN   = 4;

  logic clk = 1'b0;
  logic resetn;
  logic clr;

  always #5 clk = ~clk;

  max_serial_if #(.WIDTH(WIDTH), .LEN(LEN)) u_if ();

  max_serial #(.WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .bus    (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: samples of the open frame and the last result.
  int frame[$];
  int exp_valid;
  int exp_data;
  int exp_idx;

  int cyc = 0;
  int pulses = 0;
  int last_pulse = 0;
  int prev_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(u_if.out_valid), 32'(exp_valid));
    chk("data_out",  32'(u_if.data_out),  32'(exp_data));
    chk("busy",      32'(u_if.busy),      32'(frame.size() != 0));
`ifdef MAX_SERIAL_ARGMAX_EN
    chk("index_out", 32'(u_if.index_out), 32'(exp_idx));
`endif
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input bit v, input int d, input bit c);
    int best;
    int bi;
    u_if.in_valid = v;
    u_if.data_in  = WIDTH'(d);
    clr           = c;
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 0;
    if (c) frame.delete();
    if (v) begin
      frame.push_back(d);
      if (frame.size() == LEN) begin
        best = frame[0];
        bi   = 0;
        for (int i = 1; i < LEN; i++)
          if (frame[i] > best) begin
            best = frame[i];
            bi   = i;
          end
        exp_valid = 1;
        exp_data  = best;
        exp_idx   = bi;
        frame.delete();
      end
    end
    check_outputs();
    if (u_if.out_valid) begin
      pulses++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
    u_if.in_valid = 1'b0;
    clr           = 1'b0;
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #3;
    resetn = 1'b0;
    #1;
    frame.delete();
    exp_valid = 0;
    exp_data  = 0;
    exp_idx   = 0;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    resetn = 1'b1;
  endtask

  task automatic feed(input int a, input int b, input int c, input int d);
    cycle(1, a, 0);
    cycle(1, b, 0);
    cycle(1, c, 0);
    cycle(1, d, 0);
  endtask

  int p0;

  initial begin
    resetn        = 1'b1;
    clr           = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.data_in  = '0;
    exp_valid     = 0;
    exp_data      = 0;
    exp_idx       = 0;
    #1;
    do_reset();

    // Contiguous frame 3,9,2,7.
    p0 = pulses;
    feed(3, 9, 2, 7);
    cycle(0, 0, 0);
    chk("s1_pulses", 32'(pulses - p0), 32'd1);
    chk("s1_data", 32'(u_if.data_out), 32'd9);

    // Ties with gaps of two idle cycles.
    p0 = pulses;
    cycle(1, 5, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 5, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 1, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 5, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    chk("s2_pulses", 32'(pulses - p0), 32'd1);
    chk("s2_data", 32'(u_if.data_out), 32'd5);

    // Back-to-back frames.
    p0 = pulses;
    feed(1, 2, 3, 4);
    feed(8, 7, 6, 5);
    cycle(0, 0, 0);
    chk("s3_pulses", 32'(pulses - p0), 32'd2);
    chk("s3_spacing", 32'(last_pulse - prev_pulse), 32'd4);
    chk("s3_data", 32'(u_if.data_out), 32'd8);

    // clr with a sample restarts the frame; 200 is discarded.
    p0 = pulses;
    cycle(1, 200, 0);
    cycle(1, 1, 0);
    cycle(1, 10, 1);
    cycle(1, 11, 0);
    cycle(1, 12, 0);
    cycle(1, 13, 0);
    cycle(0, 0, 0);
    chk("s4_pulses", 32'(pulses - p0), 32'd1);
    chk("s4_data", 32'(u_if.data_out), 32'd13);

    // clr on the last sample suppresses the result.
    p0 = pulses;
    cycle(1, 90, 0);
    cycle(1, 91, 0);
    cycle(1, 92, 0);
    cycle(1, 93, 1);
    cycle(0, 0, 0);
    chk("s5_pulses", 32'(pulses - p0), 32'd0);
    chk("s5_data", 32'(u_if.data_out), 32'd13);
    cycle(0, 0, 1);

    // Reset mid-frame, then a fresh frame.
    p0 = pulses;
    cycle(1, 77, 0);
    cycle(1, 78, 0);
    do_reset();
    feed(0, 0, 0, 255);
    cycle(0, 0, 0);
    chk("s6_pulses", 32'(pulses - p0), 32'd1);
    chk("s6_data", 32'(u_if.data_out), 32'd255);

    // Unsigned compare: 255 stays the maximum.
    feed(255, 0, 0, 0);
    cycle(0, 0, 0);
    chk("s7_data", 32'(u_if.data_out), 32'd255);

    // Randomized traffic with gaps, clr and frequent ties.
    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_max_serial

`default_nettype wire

// File: doc/max_serial.md
MAX_SERIAL -- requirements
Module: max_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits (unsigned).
REQ-002 SHALL have parameter LEN, default 8, samples per frame; legal range LEN >= 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous frame abort/restart.
REQ-006 SHALL have port in_valid, input, 1, data_in carries a sample this cycle.
REQ-007 SHALL have port data_in, input, WIDTH, sample value.
REQ-008 SHALL have port out_valid, output, 1, one-cycle pulse marking a completed frame.
REQ-009 SHALL have port data_out, output, WIDTH, maximum of the last completed frame.
REQ-010 SHALL have port index_out, output, IW = max(1, $clog2(LEN)), position of that maximum within the frame; present only under REQ-030.
REQ-011 SHALL have port busy, output, 1, high while a frame is partially accumulated.

Function
REQ-012 SHALL accept one sample per cycle with in_valid high; it has no backpressure and accepts every sample.
REQ-013 SHALL keep a sample counter cnt (IW bits) and a two-state FSM: FIRST (cnt = 0) and ACC (0 < cnt < LEN).
REQ-014 In FIRST, an accepted sample SHALL load run_max <= data_in and run_idx <= 0, set cnt <= 1, and move to ACC.
REQ-015 In ACC, an accepted sample SHALL update run_max/run_idx only if data_in > run_max (unsigned, strict), then increment cnt.
REQ-016 On ties, the earliest index SHALL be kept; data_out is identical either way.
REQ-017 When the accepted sample has cnt = LEN-1, the block SHALL take the final max over run_max and that sample, register it to data_out/index_out, pulse out_valid high for exactly the next cycle, and return to FIRST with cnt <= 0.
REQ-018 Latency SHALL be one clock, from the edge that samples the last in_valid to out_valid high.
REQ-019 data_out/index_out SHALL hold until the next completed frame; they SHALL NOT change while out_valid is low.
REQ-020 Cycles with in_valid low SHALL leave cnt, run_max, run_idx and the FSM unchanged, so gaps in the stream are allowed.
REQ-021 clr high SHALL discard the partial frame and force FIRST; with clr and in_valid both high, that sample SHALL be processed as sample 0 of a new frame.
REQ-022 clr coinciding with the last sample of a frame SHALL suppress that frame's out_valid and leave data_out unchanged.
REQ-023 busy SHALL equal (state == ACC).
REQ-024 Back-to-back frames SHALL be supported: a FIRST-state sample may arrive in the same cycle out_valid is high.

Reset
REQ-025 While resetn is low, the block SHALL asynchronously force FIRST, cnt = 0, run_max = 0, run_idx = 0, out_valid = 0, data_out = 0, index_out = 0, and busy = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame without emitting out_valid.
REQ-027 After resetn deasserts, the first accepted sample SHALL be sample 0 of a frame.

Configuration
REQ-028 The macro MAX_SERIAL_ARGMAX_EN SHALL control the index tracking feature.
REQ-029 Without MAX_SERIAL_ARGMAX_EN, the block SHALL have no index_out port and no run_idx register; the value path is unchanged.
REQ-030 With MAX_SERIAL_ARGMAX_EN defined, the block SHALL include run_idx, the index_out port, and the tie rule of REQ-016.

Verification
REQ-031 WIDTH=8, LEN=4; samples 3,9,2,7 on consecutive cycles -> out_valid one cycle after the 7, data_out=9, index_out=1.
REQ-032 LEN=4; samples 5,5,1,5 with in_valid gaps of 2 cycles between samples -> data_out=5, index_out=0, exactly one out_valid pulse.
REQ-033 LEN=4; 8 contiguous samples 1,2,3,4,8,7,6,5 -> two pulses, 4 cycles apart: (4, idx 3) then (8, idx 0).
REQ-034 LEN=4; samples 200,1 then clr together with sample 10, followed by 11,12,13 -> single result data_out=13, index_out=3; 200 is never reported.
REQ-035 resetn low after the 2nd of 4 samples, then 4 fresh samples 0,0,0,255 -> no pulse from the aborted frame; result 255, index_out=3; all outputs 0 during reset.
REQ-036 WIDTH=8; samples 255,0,0,0 -> data_out=255, confirming unsigned compare; repeat without MAX_SERIAL_ARGMAX_EN and confirm data_out matches.
